jtag_tap_core: RTL and testbench
================================

// Module: jtag_tap_core
// PURPOSE
//  Oversampled IEEE 1149.1 TAP for tt_um_obriensp_jtag; sits directly behind the ui_in/uo_out pins.
//  Synchronises TCK/TMS/TDI into clk and detects TCK edges.
//  Runs the 16-state TAP FSM, IR, and IDCODE/BYPASS/USER data registers.
//  Drives TDO and exposes a parallel USER register to the core logic.
// PARAMETERS
//  IR_W     4              instruction register width (>=2)
//  IDCODE   32'h1BEEF0FF   IDCODE DR value; bit0 must be 1
//  USER_W   8              USER data register width (>=1)
// PORTS
//  clk               in   1       system clock; TCK high and low phases >= 4 clk periods each
//  rst_n             in   1       synchronous active-low reset
//  tck               in   1       JTAG clock pin (asynchronous to clk)
//  tms               in   1       JTAG mode select pin
//  tdi               in   1       JTAG data in pin
//  tdo               out  1       JTAG data out
//  tdo_oe            out  1       1 = tdo valid/driven (Shift-DR/Shift-IR only)
//  tap_state         out  4       current FSM state code (see below)
//  ir                out  IR_W    active instruction
//  user_capture_data in   USER_W  loaded into USER DR on Capture-DR
//  user_update_data  out  USER_W  USER DR value latched at Update-DR
//  user_update       out  1       one-clk pulse when user_update_data is written
// BEHAVIOUR
//  Synchronisation and edge detection
//  - 2-FF synchronisers on tck, tms, tdi; a third FF on tck for edge detect.
//  - rise = sync_tck & ~prev_tck; fall = ~sync_tck & prev_tck.
//  - tms/tdi are sampled from their sync FFs in the rise cycle.
//  - Pin TCK rise to tap_state change: 3 clk cycles. Between edges, no state changes.
//  State codes
//  - 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauDR, 7 Ex2DR, 8 UpdDR,
//  - 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauIR, 14 Ex2IR, 15 UpdIR.
//  - Transitions on rise per 1149.1. Five consecutive TMS=1 rises reach TLR from any state.
//  Instructions
//  - 1 = IDCODE, 8 = USER, all ones = BYPASS; any other value selects BYPASS.
//  - ir <= 1 while in TLR.
//  Rise actions (keyed on the state before the transition)
//  - CapIR: ir_sr <= {0..,2'b01}.
//  - CapDR: dr_sr <= IDCODE (IDCODE), 0 (BYPASS, 1 bit), user_capture_data (USER).
//  - ShIR/ShDR: selected shift reg shifts right; tdi enters the MSB of the active length.
//    The shift also happens on the rise that exits to Ex1.
//  - Entering UpdIR: ir <= ir_sr.
//  - Entering UpdDR with USER: user_update_data <= dr_sr[USER_W-1:0]; user_update=1 for 1 clk.
//  Fall actions
//  - tdo <= LSB of the selected shift reg when state is ShDR/ShIR, else 0.
//  - tdo_oe <= (state==ShDR || state==ShIR). Both change only on fall.
//  Reset (rst_n=0 at a clk edge, including mid-scan)
//  - tap_state=0, ir=1, shift regs=0, tdo=0, tdo_oe=0, user_update_data=0, user_update=0,
//    sync/prev FFs=0. Takes effect at that clk edge.
//  Boundaries
//  - Simultaneous rise and fall cannot occur.
//  - Pause states hold shift contents.
//  - USER DR contents are unchanged if Update-DR is reached with another instruction selected.
// TESTING
//  1 reset, then 5 TCK with TMS=1 -> tap_state=0, ir=4'h1, tdo_oe=0.
//  2 TLR->RTI->SelDR->CapDR->ShDR, 32 TCK -> tdo bits = 32'h1BEEF0FF, LSB first; tdo_oe=1 during the shift.
//  3 IR scan shifting in 4'h8 -> first 4 tdo bits 1,0,0,0; after UpdIR ir=4'h8.
//  4 USER selected, user_capture_data=8'hA5, shift in 8'h3C -> tdo outputs A5 LSB first;
//    at UpdDR user_update_data=8'h3C and user_update high exactly 1 clk.
//  5 ir=4'h5 (unknown, i.e. BYPASS): shift 1,0,1,1 -> tdo 0,1,0,1 (1-TCK delay, leading 0).
//  6 rst_n=0 for 1 clk mid-ShDR -> next clk tap_state=0, ir=1, tdo=0, tdo_oe=0, user_update=0.

Source files
------------

// File: rtl/jtag_tap_core.sv
// Oversampled IEEE 1149.1 TAP controller.
// TCK/TMS/TDI are synchronised into clk. Each TCK edge is seen as a one-clk rise or
// fall strobe, and every TAP action happens on one of those strobes.
module jtag_tap_core #(
  parameter int unsigned IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1BEEF0FF,
  parameter int unsigned USER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir,
  input  logic [USER_W-1:0] user_capture_data,
  output logic [USER_W-1:0] user_update_data,
  output logic              user_update
);

  // The DR shifter is shared by IDCODE, BYPASS and USER, so it must hold the widest of them.
  localparam int unsigned DrW  = (USER_W > 32) ? USER_W : 32;
  localparam int unsigned IdxW = $clog2(DrW);

  localparam logic [IR_W-1:0] IrIdcode = IR_W'(1);
  localparam logic [IR_W-1:0] IrUser   = IR_W'(8);

  typedef enum logic [3:0] {
    StTlr   = 4'd0,
    StRti   = 4'd1,
    StSelDr = 4'd2,
    StCapDr = 4'd3,
    StShDr  = 4'd4,
    StEx1Dr = 4'd5,
    StPauDr = 4'd6,
    StEx2Dr = 4'd7,
    StUpdDr = 4'd8,
    StSelIr = 4'd9,
    StCapIr = 4'd10,
    StShIr  = 4'd11,
    StEx1Ir = 4'd12,
    StPauIr = 4'd13,
    StEx2Ir = 4'd14,
    StUpdIr = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrUser
  } dr_sel_e;

  // Pin synchronisers, packed as {tck, tms, tdi}.
  logic [2:0] pin_meta_q, pin_meta_d;
  logic [2:0] pin_sync_q, pin_sync_d;
  logic       tck_prev_q, tck_prev_d;

  logic tck_rise, tck_fall, tms_s, tdi_s;

  tap_state_e state_q, state_d;

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
  logic [DrW-1:0]    dr_sr_q, dr_sr_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;
  logic [USER_W-1:0] upd_data_q, upd_data_d;
  logic              user_update_q, user_update_d;

  dr_sel_e           dr_sel;
  logic [IdxW-1:0]   dr_msb;

  // Synchroniser shift chain, plus one extra tck stage for edge detection.
  always_comb begin
    pin_meta_d = {tck, tms, tdi};
    pin_sync_d = pin_meta_q;
    tck_prev_d = pin_sync_q[2];
  end

  assign tck_rise = pin_sync_q[2] & ~tck_prev_q;
  assign tck_fall = ~pin_sync_q[2] & tck_prev_q;
  assign tms_s    = pin_sync_q[1];
  assign tdi_s    = pin_sync_q[0];

  // Decode the active instruction into a DR selection and that register's MSB index.
  always_comb begin
    dr_sel = DrBypass;
    dr_msb = '0;
    if (ir_q == IrIdcode) begin
      dr_sel = DrIdcode;
      dr_msb = IdxW'(31);
    end else if ((IR_W >= 4) && (ir_q == IrUser)) begin
      dr_sel = DrUser;
      dr_msb = IdxW'(USER_W - 1);
    end
  end

  // TAP next-state logic; the state only advances on a TCK rise.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        StTlr:   state_d = tms_s ? StTlr   : StRti;
        StRti:   state_d = tms_s ? StSelDr : StRti;
        StSelDr: state_d = tms_s ? StSelIr : StCapDr;
        StCapDr: state_d = tms_s ? StEx1Dr : StShDr;
        StShDr:  state_d = tms_s ? StEx1Dr : StShDr;
        StEx1Dr: state_d = tms_s ? StUpdDr : StPauDr;
        StPauDr: state_d = tms_s ? StEx2Dr : StPauDr;
        StEx2Dr: state_d = tms_s ? StUpdDr : StShDr;
        StUpdDr: state_d = tms_s ? StSelDr : StRti;
        StSelIr: state_d = tms_s ? StTlr   : StCapIr;
        StCapIr: state_d = tms_s ? StEx1Ir : StShIr;
        StShIr:  state_d = tms_s ? StEx1Ir : StShIr;
        StEx1Ir: state_d = tms_s ? StUpdIr : StPauIr;
        StPauIr: state_d = tms_s ? StEx2Ir : StPauIr;
        StEx2Ir: state_d = tms_s ? StUpdIr : StShIr;
        StUpdIr: state_d = tms_s ? StSelDr : StRti;
        default: state_d = StTlr;
      endcase
    end
  end

  // Register datapath: capture/shift/update on rise, TDO launch on fall.
  always_comb begin
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    dr_sr_d       = dr_sr_q;
    tdo_d         = tdo_q;
    tdo_oe_d      = tdo_oe_q;
    upd_data_d    = upd_data_q;
    user_update_d = 1'b0;

    if (tck_rise) begin
      case (state_q)
        StCapIr: ir_sr_d = IR_W'(1);
        StShIr:  ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
        StCapDr: begin
          case (dr_sel)
            DrIdcode: dr_sr_d = DrW'(IDCODE);
            DrUser:   dr_sr_d = DrW'(user_capture_data);
            default:  dr_sr_d = '0;
          endcase
        end
        StShDr: begin
          // Every selected register enters tdi at its own MSB; bits above it stay zero
          // because capture clears the whole shifter.
          dr_sr_d         = dr_sr_q >> 1;
          dr_sr_d[dr_msb] = tdi_s;
        end
        default: ;
      endcase

      // Only Ex1/Ex2 lead into the update states, so the shifters are stable here.
      if (state_d == StUpdIr) begin
        ir_d = ir_sr_q;
      end
      if ((state_d == StUpdDr) && (dr_sel == DrUser)) begin
        upd_data_d    = dr_sr_q[USER_W-1:0];
        user_update_d = 1'b1;
      end
    end

    if (tck_fall) begin
      tdo_oe_d = (state_q == StShDr) || (state_q == StShIr);
      if (state_q == StShDr) begin
        tdo_d = dr_sr_q[0];
      end else if (state_q == StShIr) begin
        tdo_d = ir_sr_q[0];
      end else begin
        tdo_d = 1'b0;
      end
    end

    // Test-Logic-Reset forces IDCODE.
    if (state_d == StTlr) begin
      ir_d = IrIdcode;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_meta_q    <= '0;
      pin_sync_q    <= '0;
      tck_prev_q    <= 1'b0;
      state_q       <= StTlr;
      ir_q          <= IrIdcode;
      ir_sr_q       <= '0;
      dr_sr_q       <= '0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
      upd_data_q    <= '0;
      user_update_q <= 1'b0;
    end else begin
      pin_meta_q    <= pin_meta_d;
      pin_sync_q    <= pin_sync_d;
      tck_prev_q    <= tck_prev_d;
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      dr_sr_q       <= dr_sr_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
      upd_data_q    <= upd_data_d;
      user_update_q <= user_update_d;
    end
  end

  assign tdo              = tdo_q;
  assign tdo_oe           = tdo_oe_q;
  assign tap_state        = state_q;
  assign ir               = ir_q;
  assign user_update_data = upd_data_q;
  assign user_update      = user_update_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: directed scans plus randomized TCK/TMS/TDI checked against a
// table-driven TAP model that keeps its shift registers as bit queues.
module tb_jtag_tap_core;

  localparam int unsigned IR_W   = 4;
  localparam int unsigned USER_W = 8;
  localparam logic [31:0] IDCODE = 32'h1BEEF0FF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tck = 1'b0;
  logic              tms = 1'b0;
  logic              tdi = 1'b0;
  logic              tdo;
  logic              tdo_oe;
  logic [3:0]        tap_state;
  logic [IR_W-1:0]   ir;
  logic [USER_W-1:0] ucap = '0;
  logic [USER_W-1:0] uupd;
  logic              uupd_p;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  jtag_tap_core #(
    .IR_W  (IR_W),
    .IDCODE(IDCODE),
    .USER_W(USER_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tck              (tck),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .tdo_oe           (tdo_oe),
    .tap_state        (tap_state),
    .ir               (ir),
    .user_capture_data(ucap),
    .user_update_data (uupd),
    .user_update      (uupd_p)
  );

  always #5 clk = ~clk;

  // Count clk cycles with user_update high; a correct pulse adds exactly one.
  always @(negedge clk) if (uupd_p === 1'b1) pulses++;

  // ---------------- reference model ----------------
  // Next-state tables indexed by state code, for TMS=0 and TMS=1.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int m_state;
  int m_ir;
  bit m_irq[$];
  bit m_drq[$];
  bit m_tdo;
  bit m_oe;
  int m_upd;
  int m_pulses = 0;

  function automatic int q_val(input bit q[$]);
    int v = 0;
    for (int i = 0; i < q.size(); i++) if (q[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int dr_len(input int instr);
    if (instr == 1) return 32;
    if (instr == 8) return USER_W;
    return 1;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_ir    = 1;
    m_irq.delete();
    m_drq.delete();
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
    m_upd   = 0;
  endfunction

  function automatic void model_rise(input bit t_ms, input bit t_di);
    int s = m_state;
    int n = t_ms ? nxt1[s] : nxt0[s];
    logic [31:0] cap;
    cap = (m_ir == 1) ? IDCODE : (m_ir == 8) ? 32'(ucap) : 32'd0;
    if (s == 10) begin
      m_irq.delete();
      for (int i = 0; i < IR_W; i++) m_irq.push_back(i == 0);
    end
    if (s == 3) begin
      m_drq.delete();
      for (int i = 0; i < dr_len(m_ir); i++) m_drq.push_back(cap[i]);
    end
    if (s == 11 && m_irq.size() > 0) begin
      void'(m_irq.pop_front());
      m_irq.push_back(t_di);
    end
    if (s == 4 && m_drq.size() > 0) begin
      void'(m_drq.pop_front());
      m_drq.push_back(t_di);
    end
    if (n == 15) m_ir = q_val(m_irq);
    if (n == 8 && m_ir == 8) begin
      m_upd = q_val(m_drq);
      m_pulses++;
    end
    if (n == 0) m_ir = 1;
    m_state = n;
  endfunction

  function automatic void model_fall();
    m_oe  = (m_state == 4) || (m_state == 11);
    m_tdo = 1'b0;
    if (m_state == 4 && m_drq.size() > 0) m_tdo = m_drq[0];
    if (m_state == 11 && m_irq.size() > 0) m_tdo = m_irq[0];
  endfunction

  // ---------------- stimulus helpers ----------------
  // One full TCK period; seen is the TDO value presented before the rise.
  task automatic tck_cycle(input bit t_ms, input bit t_di, output bit seen);
    seen = tdo;
    tms = t_ms;
    tdi = t_di;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (6) @(negedge clk);
    tck = 1'b0;
    model_fall();
    repeat (6) @(negedge clk);
  endtask

  task automatic go(input bit t_ms);
    bit d;
    tck_cycle(t_ms, 1'b0, d);
  endtask

  // From RTI: full IR scan loading val, back to RTI. Returns TDO bits seen during the shift.
  task automatic load_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] seen);
    bit b;
    go(1'b1); go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < IR_W; i++) begin
      tck_cycle(i == IR_W - 1, val[i], b);
      seen[i] = b;
    end
    go(1'b1);
    go(1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    tests++; if (tap_state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", tap_state); end
    tests++; if (ir !== 4'h1) begin fails++; $display("FAIL reset_ir: got %0h want 1", ir); end
    tests++; if (tdo !== 1'b0) begin fails++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    tests++; if (tdo_oe !== 1'b0) begin fails++; $display("FAIL reset_tdo_oe: got %b want 0", tdo_oe); end
    tests++; if (uupd !== 8'h00) begin fails++; $display("FAIL reset_user_data: got %0h want 0", uupd); end
    tests++; if (uupd_p !== 1'b0) begin fails++; $display("FAIL reset_user_update: got %b want 0", uupd_p); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) go(1'b1);
    tests++; if (tap_state !== 4'd0) begin fails++; $display("FAIL tlr_state: got %0d want 0", tap_state); end
    tests++; if (ir !== 4'h1) begin fails++; $display("FAIL tlr_ir: got %0h want 1", ir); end
    tests++; if (tdo_oe !== 1'b0) begin fails++; $display("FAIL tlr_tdo_oe: got %b want 0", tdo_oe); end
  endtask

  task automatic test_idcode();
    logic [31:0] word;
    int oe_bad = 0;
    bit b;
    go(1'b0); go(1'b1); go(1'b0); go(1'b0);
    tests++; if (tap_state !== 4'd4) begin fails++; $display("FAIL idcode_enter_shdr: got %0d want 4", tap_state); end
    for (int i = 0; i < 32; i++) begin
      if (tdo_oe !== 1'b1) oe_bad++;
      tck_cycle(i == 31, 1'($urandom_range(0, 1)), b);
      word[i] = b;
    end
    tests++; if (word !== 32'h1BEEF0FF) begin fails++; $display("FAIL idcode_tdo: got %h want 1beef0ff", word); end
    tests++; if (oe_bad != 0) begin fails++; $display("FAIL idcode_tdo_oe: got %0d low samples want 0", oe_bad); end
    tests++; if (tdo_oe !== 1'b0 || tap_state !== 4'd5) begin
      fails++; $display("FAIL idcode_exit: got state %0d oe %b want state 5 oe 0", tap_state, tdo_oe);
    end
    go(1'b1);
    go(1'b0);
  endtask

  task automatic test_ir_user();
    logic [IR_W-1:0] seen;
    load_ir(4'h8, seen);
    tests++; if (seen !== 4'b0001) begin fails++; $display("FAIL ir_capture_tdo: got %b want 0001", seen); end
    tests++; if (ir !== 4'h8) begin fails++; $display("FAIL ir_update: got %0h want 8", ir); end
  endtask

  task automatic test_user();
    logic [7:0] word;
    int p0;
    bit b;
    ucap = 8'hA5;
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 8; i++) begin
      tck_cycle(i == 7, 1'((8'h3C >> i) & 8'h01), b);
      word[i] = b;
    end
    tests++; if (word !== 8'hA5) begin fails++; $display("FAIL user_capture_tdo: got %h want a5", word); end
    p0 = pulses;
    go(1'b1);
    tests++; if (uupd !== 8'h3C) begin fails++; $display("FAIL user_update_data: got %h want 3c", uupd); end
    tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL user_update_pulse: got %0d cycles want 1", pulses - p0); end
    go(1'b0);
  endtask

  task automatic test_bypass();
    logic [IR_W-1:0] seen_ir;
    logic [3:0] seen;
    logic [3:0] pat;
    int p0;
    bit b;
    pat = 4'b1101;
    load_ir(4'h5, seen_ir);
    tests++; if (ir !== 4'h5) begin fails++; $display("FAIL bypass_ir: got %0h want 5", ir); end
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, pat[i], b);
      seen[i] = b;
    end
    tests++; if (seen !== 4'b1010) begin fails++; $display("FAIL bypass_tdo: got %b want 1010", seen); end
    p0 = pulses;
    go(1'b1);
    tests++; if (uupd !== 8'h3C) begin fails++; $display("FAIL bypass_user_hold: got %h want 3c", uupd); end
    tests++; if (pulses != p0) begin fails++; $display("FAIL bypass_no_pulse: got %0d cycles want 0", pulses - p0); end
    go(1'b0);
  endtask

  task automatic test_pause();
    logic [IR_W-1:0] seen_ir;
    logic [31:0] word;
    bit b;
    load_ir(4'h1, seen_ir);
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 6; i++) begin
      tck_cycle(i == 5, 1'($urandom_range(0, 1)), b);
      word[i] = b;
    end
    go(1'b0);
    tests++; if (tap_state !== 4'd6 || tdo_oe !== 1'b0) begin
      fails++; $display("FAIL pause_state: got state %0d oe %b want state 6 oe 0", tap_state, tdo_oe);
    end
    go(1'b0); go(1'b0);
    go(1'b1); go(1'b0);
    for (int i = 6; i < 32; i++) begin
      tck_cycle(i == 31, 1'($urandom_range(0, 1)), b);
      word[i] = b;
    end
    tests++; if (word !== 32'h1BEEF0FF) begin fails++; $display("FAIL pause_hold_tdo: got %h want 1beef0ff", word); end
    go(1'b1);
    go(1'b0);
  endtask

  task automatic test_random();
    logic [IR_W-1:0] seen_ir;
    logic [IR_W-1:0] instr;
    bit b;
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 5; i++) go(1'b1);
      go(1'b0);
      case ($urandom_range(0, 3))
        0:       instr = 4'h1;
        1:       instr = 4'h8;
        2:       instr = 4'hF;
        default: instr = 4'($urandom_range(0, 15));
      endcase
      load_ir(instr, seen_ir);
      for (int s = 0; s < 60; s++) begin
        ucap = 8'($urandom_range(0, 255));
        tck_cycle($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), b);
        tests++; if (tap_state !== 4'(m_state)) begin
          fails++; $display("FAIL rand_state: got %0d want %0d", tap_state, m_state);
        end
        tests++; if (ir !== 4'(m_ir)) begin fails++; $display("FAIL rand_ir: got %0h want %0h", ir, m_ir); end
        tests++; if (tdo !== m_tdo) begin fails++; $display("FAIL rand_tdo: got %b want %b", tdo, m_tdo); end
        tests++; if (tdo_oe !== m_oe) begin fails++; $display("FAIL rand_tdo_oe: got %b want %b", tdo_oe, m_oe); end
      end
    end
    tests++; if (uupd !== 8'(m_upd)) begin fails++; $display("FAIL rand_user_data: got %h want %h", uupd, m_upd); end
    tests++; if (pulses != m_pulses) begin fails++; $display("FAIL rand_user_pulses: got %0d want %0d", pulses, m_pulses); end
  endtask

  task automatic test_tlr5();
    for (int i = 0; i < 7; i++) go(1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) go(1'b1);
    tests++; if (tap_state !== 4'd0) begin fails++; $display("FAIL tlr5_state: got %0d want 0", tap_state); end
    tests++; if (ir !== 4'h1) begin fails++; $display("FAIL tlr5_ir: got %0h want 1", ir); end
  endtask

  task automatic test_reset_mid();
    bit b;
    go(1'b0); go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, b);
    tests++; if (tdo_oe !== 1'b1) begin fails++; $display("FAIL mid_pre_oe: got %b want 1", tdo_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tests++; if (tap_state !== 4'd0) begin fails++; $display("FAIL mid_reset_state: got %0d want 0", tap_state); end
    tests++; if (ir !== 4'h1) begin fails++; $display("FAIL mid_reset_ir: got %0h want 1", ir); end
    tests++; if (tdo !== 1'b0) begin fails++; $display("FAIL mid_reset_tdo: got %b want 0", tdo); end
    tests++; if (tdo_oe !== 1'b0) begin fails++; $display("FAIL mid_reset_oe: got %b want 0", tdo_oe); end
    tests++; if (uupd_p !== 1'b0) begin fails++; $display("FAIL mid_reset_pulse: got %b want 0", uupd_p); end
    tests++; if (uupd !== 8'h00) begin fails++; $display("FAIL mid_reset_user_data: got %h want 0", uupd); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_user();
    test_user();
    test_bypass();
    test_pause();
    test_random();
    test_tlr5();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
